// File: rtl/rs232_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : rs232_bit_feeder
// Brief    : Receives 8N1 RS232 bytes into a FIFO and feeds them out one bit
//            per modulator request, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module rs232_bit_feeder #(
    parameter int   CLKS_PER_BIT = 10,
    parameter int   FIFO_DEPTH   = 8,
    parameter logic IDLE_BIT     = 1'b0
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          rx,
    input  logic                          data_rdy,
    output logic                          data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underrun,
    output logic                          overflow,
    output logic                          framing_err
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    // Synchronizer and edge history reset high so an idle line never looks like a start
    logic r_rx_meta, r_rx_sync, r_rx_prev;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    rx_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_rx_byte;
    logic               r_framing_err;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_rx_byte     <= '0;
            r_framing_err <= 1'b0;
        end else begin
            r_framing_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_state <= S_START;
                        r_cnt   <= c_HALF;
                    end
                end
                S_START: begin
                    if (r_cnt == '0) begin
                        if (!r_rx_sync) begin
                            r_state   <= S_DATA;
                            r_cnt     <= c_FULL;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
                        r_cnt     <= c_FULL;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == '0) begin
                        r_framing_err <= !r_rx_sync;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [7:0]         r_ser;
    logic [2:0]         r_idx;
    logic               r_loaded;
    logic               r_underrun, r_overflow;

    logic w_push, w_push_ok, w_need_load, w_pop, w_empty, w_full;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_DEPTH);
    assign w_push      = (r_state == S_STOP) && (r_cnt == '0) && r_rx_sync;
    assign w_need_load = data_rdy && (!r_loaded || (r_idx == 3'd7));
    assign w_pop       = w_need_load && !w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign w_push_ok   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_rx_byte;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ser      <= '0;
            r_idx      <= '0;
            r_loaded   <= 1'b0;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_underrun <= w_need_load && w_empty;
            r_overflow <= w_push && !w_push_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_need_load) begin
                r_idx    <= '0;
                r_loaded <= w_pop;
                if (w_pop) begin
                    r_ser <= r_mem[r_rd_ptr];
                end
            end else if (data_rdy) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign data        = r_loaded ? r_ser[r_idx] : IDLE_BIT;
    assign fifo_count  = r_count;
    assign underrun    = r_underrun;
    assign overflow    = r_overflow;
    assign framing_err = r_framing_err;

endmodule
`default_nettype wire

// File: tb/tb_rs232_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs232_bit_feeder
// Brief    : Directed bench for rs232_bit_feeder; serial bit expectations go
//            through a scoreboard queue checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs232_bit_feeder;

    logic       clk;
    logic       n_reset;
    logic       rx;
    logic       data_rdy;
    logic       data;
    logic [3:0] fifo_count;
    logic       underrun;
    logic       overflow;
    logic       framing_err;

    rs232_bit_feeder #(
        .CLKS_PER_BIT (10),
        .FIFO_DEPTH   (8),
        .IDLE_BIT     (1'b0)
    ) u_dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .rx          (rx),
        .data_rdy    (data_rdy),
        .data        (data),
        .fifo_count  (fifo_count),
        .underrun    (underrun),
        .overflow    (overflow),
        .framing_err (framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic d;
        logic u;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   fe_cnt  = 0;
    int   ov_cnt  = 0;
    int   ur_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: each accepted strobe must yield the next queued bit/underrun pair
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (data_rdy && n_reset) begin
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_strobe", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("data", int'(data), int'(e.d));
                    check("underrun", int'(underrun), int'(e.u));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (framing_err) fe_cnt++;
            if (overflow)    ov_cnt++;
            if (underrun)    ur_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(negedge clk);
        end
        rx = stop;
        repeat (10) @(negedge clk);
        rx = 1'b1;
    endtask

    // n back-to-back strobes; strobe k must present exp_bits[k]
    task automatic strobe_seq(input logic [7:0] exp_bits, input int n, input logic exp_ur);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.d = exp_bits[k];
            e.u = exp_ur;
            sb_q.push_back(e);
        end
        @(negedge clk);
        data_rdy = 1'b1;
        repeat (n) @(negedge clk);
        data_rdy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_fifo_count"}, int'(fifo_count), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_framing_err"}, int'(framing_err), 0);
    endtask

    logic [7:0] abort_byte;

    initial begin
        n_reset  = 1'b1;
        rx       = 1'b1;
        data_rdy = 1'b0;
        @(negedge clk);
        n_reset = 1'b0;
        idle(3);
        check_reset_outputs("rst");
        n_reset = 1'b1;
        idle(5);

        // 0xA5 received, then popped bit by bit
        send_frame(8'hA5, 1'b1);
        idle(5);
        check("a5_count_before", int'(fifo_count), 1);
        strobe_seq(8'hA5, 1, 1'b0);
        check("a5_count_after", int'(fifo_count), 0);
        strobe_seq(8'h52, 7, 1'b0);

        // Bad stop bit
        send_frame(8'h3C, 1'b0);
        idle(20);
        check("fe_count", fe_cnt, 1);
        check("fe_fifo_count", int'(fifo_count), 0);

        // Underrun from an exhausted byte, then while unloaded
        strobe_seq(8'h00, 2, 1'b1);
        check("ur_count", ur_cnt, 2);
        send_frame(8'h01, 1'b1);
        idle(5);
        check("unloaded_count", int'(fifo_count), 1);
        check("unloaded_data", int'(data), 0);
        strobe_seq(8'h01, 1, 1'b0);
        check("after_load_count", int'(fifo_count), 0);
        check("ur_count_stable", ur_cnt, 2);

        // Short low glitch is rejected; the next frame is still received
        @(negedge clk);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        check("glitch_count", int'(fifo_count), 0);
        check("glitch_fe", fe_cnt, 1);
        send_frame(8'h5A, 1'b1);
        idle(5);
        check("post_glitch_count", int'(fifo_count), 1);

        // Asynchronous reset during data bit 4
        check("pre_reset_data", int'(data), 1);
        abort_byte = 8'h3C;
        @(negedge clk);
        rx = 1'b0;
        idle(10);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            idle(10);
        end
        rx = abort_byte[4];
        idle(5);
        #2 n_reset = 1'b0;
        #1 check_reset_outputs("midrst");
        rx = 1'b1;
        idle(3);
        n_reset = 1'b1;
        idle(20);
        check("abandoned_count", int'(fifo_count), 0);
        send_frame(8'hC3, 1'b1);
        idle(5);
        check("post_rst_count", int'(fifo_count), 1);
        strobe_seq(8'hC3, 1, 1'b0);
        check("post_rst_pop", int'(fifo_count), 0);

        // Fill past capacity
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i * 8'h11), 1'b1);
            idle(3);
            if (i == 8) begin
                check("full_count", int'(fifo_count), 8);
                check("full_no_ov", ov_cnt, 0);
            end
        end
        check("ov_count", int'(fifo_count), 8);
        check("ov_pulses", ov_cnt, 1);

        // Finish 0xC3, then the oldest queued byte must be 0x11
        strobe_seq(8'h61, 7, 1'b0);
        strobe_seq(8'h11, 8, 1'b0);
        check("drain_count", int'(fifo_count), 7);
        idle(3);
        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
